// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the RV32I multi-cycle controller: opcodes, FSM states
// and datapath select encodings.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_ERROR
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // States that stall on the shared memory port until mem_ready.
  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// Counts consecutive stalled wait-state cycles; flags the stall that would make
// the count reach TIMEOUT. Only instantiated when CTRL_TIMEOUT_EN is defined.
module ctrl_wait_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_clr,
  output logic o_expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_count;

  assign o_expired = i_en && (r_count == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Multi-cycle RV32I main controller sequencing instructions over a shared
// memory port. Optional stall watchdog enabled by defining CTRL_TIMEOUT_EN.
module riscv_multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W = 7,
  parameter int unsigned ALUOP_W  = 2,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [2:0]          funct3,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                ir_write,
  output logic                reg_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                adr_src,
  output logic [1:0]          alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          result_src,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic                instr_done,
  output logic                error
);

  state_t     r_state;
  state_t     w_next;
  logic [6:0] w_opcode;
  logic       w_expired;
  logic       w_pc_write, w_ir_write, w_reg_write, w_mem_write, w_instr_done;
  logic [1:0] w_alu_op;
  logic       w_unused;

  assign w_opcode = 7'(opcode);
  assign w_unused = ^{funct3[2:1], 1'(TIMEOUT)};

`ifdef CTRL_TIMEOUT_EN
  logic w_wait_en;

  assign w_wait_en = is_wait_state(r_state) && !mem_ready;

  ctrl_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk      (clk),
    .reset    (reset),
    .i_en     (w_wait_en),
    .i_clr    (!w_wait_en),
    .o_expired(w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif

  always_comb begin
    w_next       = r_state;
    w_pc_write   = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_mem_write  = 1'b0;
    w_instr_done = 1'b0;
    mem_read     = 1'b0;
    adr_src      = 1'b0;
    alu_src_a    = SRCA_PC;
    alu_src_b    = SRCB_RS2;
    result_src   = RES_ALUOUT;
    w_alu_op     = ALUOP_ADD;
    error        = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read   = 1'b1;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        w_ir_write = mem_ready;
        w_pc_write = mem_ready;
        if (mem_ready)      w_next = S_DECODE;
        else if (w_expired) w_next = S_ERROR;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (w_opcode)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_RTYPE:          w_next = S_EXECR;
          OP_ITYPE:          w_next = S_EXECI;
          OP_BRANCH:         w_next = S_BRANCH;
          OP_JAL:            w_next = S_JAL;
          default:           w_next = S_ERROR;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        w_next    = (w_opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_read = 1'b1;
        adr_src  = 1'b1;
        if (mem_ready)      w_next = S_MEMWB;
        else if (w_expired) w_next = S_ERROR;
      end
      S_MEMWB: begin
        result_src   = RES_MEM;
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      S_MEMWRITE: begin
        w_mem_write  = 1'b1;
        adr_src      = 1'b1;
        w_instr_done = mem_ready;
        if (mem_ready)      w_next = S_FETCH;
        else if (w_expired) w_next = S_ERROR;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        w_alu_op  = ALUOP_FUNCT;
        w_next    = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        w_alu_op  = ALUOP_FUNCT;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        result_src   = RES_ALUOUT;
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a    = SRCA_RS1;
        alu_src_b    = SRCB_RS2;
        w_alu_op     = ALUOP_SUB;
        result_src   = RES_ALUOUT;
        w_pc_write   = zero ^ funct3[0];
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      S_JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALUOUT;
        w_pc_write = 1'b1;
        w_next     = S_ALUWB;
      end
      S_ERROR: begin
        error = 1'b1;
      end
      default: w_next = S_ERROR;
    endcase
  end

  // Reset holds the state in FETCH, whose mem_ready-driven strobes must stay quiet.
  assign pc_write   = w_pc_write   && !reset;
  assign ir_write   = w_ir_write   && !reset;
  assign reg_write  = w_reg_write  && !reset;
  assign mem_write  = w_mem_write  && !reset;
  assign instr_done = w_instr_done && !reset;
  assign alu_op     = ALUOP_W'(w_alu_op);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Directed self-checking bench for riscv_multicycle_ctrl; the stall-timeout
// expectation follows whether CTRL_TIMEOUT_EN is defined.
module tb_riscv_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, ir_write, reg_write, mem_read, mem_write, adr_src;
  logic [1:0] alu_src_a, alu_src_b, result_src, alu_op;
  logic       instr_done, error;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  riscv_multicycle_ctrl #(
    .OPCODE_W(7),
    .ALUOP_W (2),
    .TIMEOUT (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .funct3    (funct3),
    .zero      (zero),
    .mem_ready (mem_ready),
    .pc_write  (pc_write),
    .ir_write  (ir_write),
    .reg_write (reg_write),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .adr_src   (adr_src),
    .alu_src_a (alu_src_a),
    .alu_src_b (alu_src_b),
    .result_src(result_src),
    .alu_op    (alu_op),
    .instr_done(instr_done),
    .error     (error)
  );

  // Field order: pc ir reg mrd mwr adr srcA srcB res aluop done err
  logic [15:0] obs;
  assign obs = {pc_write, ir_write, reg_write, mem_read, mem_write, adr_src,
                alu_src_a, alu_src_b, result_src, alu_op, instr_done, error};

  localparam logic [15:0] V_FETCH_RDY  = 16'b1_1_0_1_0_0_00_10_10_00_0_0;
  localparam logic [15:0] V_FETCH_WAIT = 16'b0_0_0_1_0_0_00_10_10_00_0_0;
  localparam logic [15:0] V_DECODE     = 16'b0_0_0_0_0_0_01_01_00_00_0_0;
  localparam logic [15:0] V_MEMADR     = 16'b0_0_0_0_0_0_10_01_00_00_0_0;
  localparam logic [15:0] V_MEMREAD    = 16'b0_0_0_1_0_1_00_00_00_00_0_0;
  localparam logic [15:0] V_MEMWB      = 16'b0_0_1_0_0_0_00_00_01_00_1_0;
  localparam logic [15:0] V_MEMWR_WAIT = 16'b0_0_0_0_1_1_00_00_00_00_0_0;
  localparam logic [15:0] V_MEMWR_RDY  = 16'b0_0_0_0_1_1_00_00_00_00_1_0;
  localparam logic [15:0] V_EXECR      = 16'b0_0_0_0_0_0_10_00_00_10_0_0;
  localparam logic [15:0] V_EXECI      = 16'b0_0_0_0_0_0_10_01_00_10_0_0;
  localparam logic [15:0] V_ALUWB      = 16'b0_0_1_0_0_0_00_00_00_00_1_0;
  localparam logic [15:0] V_BR_TAKEN   = 16'b1_0_0_0_0_0_10_00_00_01_1_0;
  localparam logic [15:0] V_BR_NOT     = 16'b0_0_0_0_0_0_10_00_00_01_1_0;
  localparam logic [15:0] V_JAL        = 16'b1_0_0_0_0_0_01_10_00_00_0_0;
  localparam logic [15:0] V_ERROR      = 16'b0_0_0_0_0_0_00_00_00_00_0_1;
  localparam logic [15:0] V_RESET      = 16'b0_0_0_1_0_0_00_10_10_00_0_0;

  task automatic chk(input string tag, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Check one cycle at the falling edge, then step past the next rising edge.
  task automatic cyc(input string tag, input logic [15:0] exp);
    @(negedge clk);
    chk(tag, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    mem_ready = 1'b1;
    opcode    = 7'b0000011;
    funct3    = 3'b000;
    zero      = 1'b0;

    cyc("reset_gating", V_RESET);
    reset = 1'b0;

    // lw, ready always high: 5 cycles
    opcode = 7'b0000011;
    cyc("lw_c1_fetch",   V_FETCH_RDY);
    cyc("lw_c2_decode",  V_DECODE);
    cyc("lw_c3_memadr",  V_MEMADR);
    cyc("lw_c4_memread", V_MEMREAD);
    cyc("lw_c5_memwb",   V_MEMWB);

    // sw with three stalled cycles in MEMWRITE: 7 cycles
    opcode = 7'b0100011;
    cyc("sw_c1_fetch",  V_FETCH_RDY);
    cyc("sw_c2_decode", V_DECODE);
    cyc("sw_c3_memadr", V_MEMADR);
    mem_ready = 1'b0;
    cyc("sw_c4_wait", V_MEMWR_WAIT);
    cyc("sw_c5_wait", V_MEMWR_WAIT);
    cyc("sw_c6_wait", V_MEMWR_WAIT);
    mem_ready = 1'b1;
    cyc("sw_c7_done", V_MEMWR_RDY);

    // R-type
    opcode = 7'b0110011;
    cyc("r_c1_fetch",  V_FETCH_RDY);
    cyc("r_c2_decode", V_DECODE);
    cyc("r_c3_exec",   V_EXECR);
    cyc("r_c4_wb",     V_ALUWB);

    // I-type, with a stalled fetch
    opcode    = 7'b0010011;
    mem_ready = 1'b0;
    cyc("i_c1_fetchwait", V_FETCH_WAIT);
    mem_ready = 1'b1;
    cyc("i_c2_fetch",  V_FETCH_RDY);
    cyc("i_c3_decode", V_DECODE);
    cyc("i_c4_exec",   V_EXECI);
    cyc("i_c5_wb",     V_ALUWB);

    // bne with zero=0: taken
    opcode = 7'b1100011;
    funct3 = 3'b001;
    zero   = 1'b0;
    cyc("bne_c1_fetch",  V_FETCH_RDY);
    cyc("bne_c2_decode", V_DECODE);
    cyc("bne_c3_branch", V_BR_TAKEN);

    // beq with zero=0: not taken
    funct3 = 3'b000;
    cyc("beq_c1_fetch",  V_FETCH_RDY);
    cyc("beq_c2_decode", V_DECODE);
    cyc("beq_c3_branch", V_BR_NOT);

    // beq with zero=1: taken; mem_ready ignored outside wait states
    zero      = 1'b1;
    cyc("beqz_c1_fetch", V_FETCH_RDY);
    mem_ready = 1'b0;
    cyc("beqz_c2_decode", V_DECODE);
    cyc("beqz_c3_branch", V_BR_TAKEN);
    mem_ready = 1'b1;
    zero      = 1'b0;

    // jal
    opcode = 7'b1101111;
    cyc("jal_c1_fetch",  V_FETCH_RDY);
    cyc("jal_c2_decode", V_DECODE);
    cyc("jal_c3_jal",    V_JAL);
    cyc("jal_c4_wb",     V_ALUWB);

    // illegal opcode: sticky ERROR until reset
    opcode = 7'b1111111;
    cyc("ill_c1_fetch",  V_FETCH_RDY);
    cyc("ill_c2_decode", V_DECODE);
    for (int i = 0; i < 10; i++) cyc("ill_error_hold", V_ERROR);
    do_reset();
    opcode = 7'b0110011;
    cyc("ill_after_reset_fetch", V_FETCH_RDY);
    cyc("ill_after_reset_decode", V_DECODE);
    do_reset();

    // asynchronous reset mid-MEMWRITE drops mem_write immediately
    opcode = 7'b0100011;
    cyc("swr_c1_fetch",  V_FETCH_RDY);
    cyc("swr_c2_decode", V_DECODE);
    cyc("swr_c3_memadr", V_MEMADR);
    mem_ready = 1'b0;
    @(negedge clk);
    chk("swr_c4_wait", V_MEMWR_WAIT);
    #2;
    reset = 1'b1;
    #1;
    chk("swr_async_reset", V_RESET);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    mem_ready = 1'b1;
    cyc("swr_after_reset_fetch", V_FETCH_RDY);
    cyc("swr_after_reset_decode", V_DECODE);
    do_reset();

    // fetch stall: watchdog fires after 4 stalled cycles, else waits forever
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) cyc("stall_fetch_wait", V_FETCH_WAIT);
`ifdef CTRL_TIMEOUT_EN
    for (int i = 0; i < 3; i++) cyc("stall_timeout_error", V_ERROR);
`else
    for (int i = 0; i < 6; i++) cyc("stall_fetch_hold", V_FETCH_WAIT);
`endif
    mem_ready = 1'b1;
    do_reset();
    cyc("final_fetch", V_FETCH_RDY);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/riscv_multicycle_ctrl.md
# riscv_multicycle_ctrl

Multi-cycle main controller for the RV32I core. It replaces the single-cycle opcode decoder with a registered state machine. Each instruction is sequenced over 3–5 cycles on one shared memory port, using a ready handshake. The block drives the datapath mux selects, ALU-op class and write strobes, and reports instruction completion and an error state.

## Interface
- `OPCODE_W`, 7, opcode field width
- `ALUOP_W`, 2, ALU-op class width (00 add, 01 sub/compare, 10 funct-decoded)
- `TIMEOUT`, 15, maximum consecutive `mem_ready`-low cycles in a wait state (only used with `CTRL_TIMEOUT_EN`)

- `clk` in 1 — the single clock; all state updates on rising edge
- `reset` in 1 — asynchronous, active-high
- `opcode` in `OPCODE_W` — from instruction register
- `funct3` in 3 — from instruction register; bit 0 selects bne (1) or beq (0)
- `zero` in 1 — ALU zero flag
- `mem_ready` in 1 — memory completed the current access this cycle
- `pc_write`, `ir_write`, `reg_write`, `mem_read`, `mem_write` out 1 each — datapath strobes
- `adr_src` out 1 — memory address: 0 = PC, 1 = ALUOut
- `alu_src_a` out 2 — 00 = PC, 01 = oldPC, 10 = rs1
- `alu_src_b` out 2 — 00 = rs2, 01 = imm, 10 = constant 4
- `result_src` out 2 — 00 = ALUOut, 01 = mem data, 10 = ALU result
- `alu_op` out `ALUOP_W` — ALU-op class
- `instr_done` out 1 — single-cycle pulse in the final cycle of each instruction
- `error` out 1 — high while in `ERROR`

## Operation
- The state register resets to `FETCH`.
- Outputs are decoded combinationally from state, plus the gating below. Unlisted outputs are 0 in each state.
- While `reset` is high, `pc_write`, `ir_write`, `reg_write`, `mem_write` and `instr_done` are forced to 0.

State sequencing:
- `FETCH`: `mem_read`=1, `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, `alu_op`=00, `result_src`=10.
  - `ir_write` and `pc_write` equal `mem_ready`.
  - Stays in `FETCH` until `mem_ready`, then goes to `DECODE`.
- `DECODE`: `alu_src_a`=01, `alu_src_b`=01, `alu_op`=00 (branch/jump target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 → `MEMADR`
  - 0110011 → `EXECR`
  - 0010011 → `EXECI`
  - 1100011 → `BRANCH`
  - 1101111 → `JAL`
  - any other opcode → `ERROR`
- `MEMADR`: `alu_src_a`=10, `alu_src_b`=01, `alu_op`=00. Goes to `MEMREAD` for lw, `MEMWRITE` for sw.
- `MEMREAD`: `mem_read`=1, `adr_src`=1. Waits for `mem_ready`, then goes to `MEMWB`.
- `MEMWB`: `result_src`=01, `reg_write`=1, `instr_done`=1. Goes to `FETCH`.
- `MEMWRITE`: `mem_write`=1, `adr_src`=1. Waits for `mem_ready`; on ready, `instr_done`=1 and next state is `FETCH`.
- `EXECR`: `alu_src_a`=10, `alu_src_b`=00, `alu_op`=10. Goes to `ALUWB`.
- `EXECI`: `alu_src_a`=10, `alu_src_b`=01, `alu_op`=10. Goes to `ALUWB`.
- `ALUWB`: `result_src`=00, `reg_write`=1, `instr_done`=1. Goes to `FETCH`.
- `BRANCH`: `alu_src_a`=10, `alu_src_b`=00, `alu_op`=01, `result_src`=00.
  - `pc_write` = `zero` XOR `funct3[0]`.
  - `instr_done`=1. Goes to `FETCH`.
- `JAL`: `alu_src_a`=01, `alu_src_b`=10, `alu_op`=00, `result_src`=00, `pc_write`=1. Goes to `ALUWB`, which writes PC+4 to rd.
- `ERROR`: all strobes 0, `error`=1. Sticky; left only by `reset`.

## Timing
- Latency with `mem_ready` always high:
  - lw: 5 cycles
  - sw, R-type, I-type, jal: 4 cycles
  - branch: 3 cycles
- Each `mem_ready`-low cycle in `FETCH`, `MEMREAD` or `MEMWRITE` adds one cycle.
- `mem_ready` is sampled only in the wait states; it is ignored elsewhere.
- An asserted `reset` in any state (including mid-`MEMWRITE`) returns to `FETCH` immediately. `mem_write` drops in the same cycle.

## Configuration
- `CTRL_TIMEOUT_EN` defined:
  - A counter of width clog2(`TIMEOUT`+1) increments on each wait-state cycle with `mem_ready`=0.
  - It clears on `mem_ready`=1, on any state change, and on reset.
  - When the count reaches `TIMEOUT` with `mem_ready` still 0, the next state is `ERROR`.
- `CTRL_TIMEOUT_EN` undefined: no counter; wait states hold indefinitely.

## Structure
- Shared package `riscv_ctrl_pkg` holds:
  - the opcode constants
  - the state enum
  - the `alu_op`, `alu_src_a`, `alu_src_b` and `result_src` encodings
- Sub-module `ctrl_wait_timer` (inputs: counter enable and clear; output: expired) is instantiated only under `CTRL_TIMEOUT_EN`.

## Test plan
- lw (0000011), `mem_ready`=1 → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; `reg_write`=1 with `result_src`=01 in cycle 5; `instr_done` in cycle 5 only.
- sw with `mem_ready` low for 3 cycles in `MEMWRITE` → `mem_write` high for 4 cycles; `instr_done` on the ready cycle; total 7 cycles.
- Branches with `zero`=0 → bne (`funct3`=001) asserts `pc_write` in cycle 3; beq (`funct3`=000) does not.
- jal (1101111) → `pc_write`=1 in cycle 3 with `result_src`=00; `reg_write`=1 in cycle 4.
- Illegal opcode 1111111 → `ERROR` after `DECODE`; `error` stays 1 for 10 cycles with all strobes 0; `reset` returns to `FETCH`.
- With `CTRL_TIMEOUT_EN` and `TIMEOUT`=4, hold `mem_ready`=0 in `FETCH` → `error`=1 after 4 wait cycles. Without the macro → remains in `FETCH`.
